rc4_prga_decryptor: RTL and testbench

//  RC4 keystream generator (PRGA) plus XOR decrypt. Runs after the key-schedule shuffle has left S[0..255] permuted in S RAM.

---
 rtl/rc4_prga_decryptor_pkg.sv | 28 ++
 rtl/rc4_prga_decryptor_trap_edge.sv | 21 ++
 rtl/rc4_prga_decryptor.sv | 153 +++++++++++++++
 tb/tb_rc4_prga_decryptor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_prga_decryptor_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt block.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_WAIT_SI,
    ST_GET_SI,
    ST_WAIT_SJ,
    ST_GET_SJ,
    ST_WRITE_J,
    ST_READ_F,
    ST_WAIT_F,
    ST_WRITE_D,
    ST_CHECK,
    ST_DONE
  } prga_state_t;

  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Lower-case letters and space are the only bytes a plausible plaintext may hold.
  function automatic logic is_printable(input logic [7:0] b);
    return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
  endfunction

endpackage

// File: rtl/rc4_prga_decryptor_trap_edge.sv
// Rising-edge detector for a level input. The pulse is combinational from the
// live input and the previous sample, so the consumer sees it on the first edge
// where the input is high.
module trap_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  // Remember last cycle's level of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/rc4_prga_decryptor.sv
// RC4 PRGA walker: for every ciphertext byte it advances i/j, swaps S[i]/S[j]
// in the external S RAM, fetches the keystream byte S[S[i]+S[j]] and writes
// ciphertext ^ keystream into the plaintext RAM. With CHECK_ASCII set, the
// first byte outside lower-case/space ends the run early with valid low.
// Memories have registered reads: data is sampled two edges after the address
// changes, which is why every read is followed by one WAIT state.
module rc4_prga_decryptor
  import rc4_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int MSG_LENGTH     = 32,
  parameter int MSG_ADDR_WIDTH = 5,
  parameter int CHECK_ASCII    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  output logic                      valid,
  output logic [ADDR_WIDTH-1:0]     s_address,
  output logic [DATA_WIDTH-1:0]     s_data,
  output logic                      s_wren,
  input  logic [DATA_WIDTH-1:0]     s_q,
  output logic [MSG_ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]     rom_q,
  output logic [MSG_ADDR_WIDTH-1:0] d_address,
  output logic [DATA_WIDTH-1:0]     d_data,
  output logic                      d_wren
);

  // state is left as a named enum so checkers can observe the walk directly.
  prga_state_t state, state_next;

  logic [ADDR_WIDTH-1:0]     i, j;
  logic [DATA_WIDTH-1:0]     si, sj, enc;
  logic [MSG_ADDR_WIDTH-1:0] k;
  logic                      start_pulse;
  logic                      byte_bad;
  logic                      last_byte;

  trap_edge u_start_edge (
    .clk   (clk),
    .rst   (reset),
    .sig   (start),
    .pulse (start_pulse)
  );

  // In CHECK, d_data still holds the byte just written, so it is judged there.
  always_comb begin
    byte_bad  = (CHECK_ASCII != 0) && !is_printable(d_data[7:0]);
    last_byte = (k == MSG_ADDR_WIDTH'(MSG_LENGTH - 1));
  end

  // Next-state sequencing: a fixed ten-state loop per byte.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_pulse) state_next = ST_INC_I;
      ST_INC_I:   state_next = ST_WAIT_SI;
      ST_WAIT_SI: state_next = ST_GET_SI;
      ST_GET_SI:  state_next = ST_WAIT_SJ;
      ST_WAIT_SJ: state_next = ST_GET_SJ;
      ST_GET_SJ:  state_next = ST_WRITE_J;
      ST_WRITE_J: state_next = ST_READ_F;
      ST_READ_F:  state_next = ST_WAIT_F;
      ST_WAIT_F:  state_next = ST_WRITE_D;
      ST_WRITE_D: state_next = ST_CHECK;
      ST_CHECK:   state_next = (byte_bad || last_byte) ? ST_DONE : ST_INC_I;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register, datapath registers and registered memory-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      enc         <= '0;
      finished    <= 1'b0;
      valid       <= 1'b0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      d_address   <= '0;
      d_data      <= '0;
      d_wren      <= 1'b0;
    end else begin
      state    <= state_next;
      finished <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start_pulse) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            valid <= 1'b0;
          end
        end
        ST_INC_I: begin
          i           <= i + ADDR_WIDTH'(1);
          s_address   <= i + ADDR_WIDTH'(1);
          rom_address <= k;
          s_wren      <= 1'b0;
          d_wren      <= 1'b0;
        end
        ST_GET_SI: begin
          si        <= s_q;
          enc       <= rom_q;
          j         <= j + s_q[ADDR_WIDTH-1:0];
          s_address <= j + s_q[ADDR_WIDTH-1:0];
        end
        ST_GET_SJ: begin
          // First half of the swap: S[i] takes S[j].
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
        end
        ST_WRITE_J: begin
          // Second half: S[j] takes the old S[i]; with i == j this rewrites the same value.
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
        end
        ST_READ_F: begin
          s_wren    <= 1'b0;
          s_address <= si[ADDR_WIDTH-1:0] + sj[ADDR_WIDTH-1:0];
        end
        ST_WRITE_D: begin
          d_address <= k;
          d_data    <= s_q ^ enc;
          d_wren    <= 1'b1;
        end
        ST_CHECK: begin
          d_wren <= 1'b0;
          if (!byte_bad) begin
            if (last_byte) valid <= 1'b1;
            else           k     <= k + MSG_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Bench for rc4_prga_decryptor: two instances (2-byte with text check, 16-byte
// without), each with S RAM / ROM / D RAM models having registered reads.
module tb_rc4_prga_decryptor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst_a, start_a, fin_a, valid_a, s_wren_a, d_wren_a;
  logic [7:0] s_addr_a, s_data_a, s_q_a, rom_q_a, d_data_a;
  logic [0:0] rom_addr_a, d_addr_a;

  logic rst_b, start_b, fin_b, valid_b, s_wren_b, d_wren_b;
  logic [7:0] s_addr_b, s_data_b, s_q_b, rom_q_b, d_data_b;
  logic [3:0] rom_addr_b, d_addr_b;

  rc4_prga_decryptor #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MSG_LENGTH(2),
                       .MSG_ADDR_WIDTH(1), .CHECK_ASCII(1)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .finished(fin_a), .valid(valid_a),
    .s_address(s_addr_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
    .rom_address(rom_addr_a), .rom_q(rom_q_a),
    .d_address(d_addr_a), .d_data(d_data_a), .d_wren(d_wren_a));

  rc4_prga_decryptor #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MSG_LENGTH(16),
                       .MSG_ADDR_WIDTH(4), .CHECK_ASCII(0)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .finished(fin_b), .valid(valid_b),
    .s_address(s_addr_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
    .rom_address(rom_addr_b), .rom_q(rom_q_b),
    .d_address(d_addr_b), .d_data(d_data_b), .d_wren(d_wren_b));

  // ---------------- memory models ----------------
  logic [7:0] m_s_init[256];
  logic [7:0] m_rom[16];
  logic [7:0] sa_mem[256], sb_mem[256];
  logic [7:0] da_mem[16], db_mem[16];
  logic load_a = 1'b0, load_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  int da_cnt, db_cnt, fa_cnt, fb_cnt;
  logic both_a, both_b;

  always @(posedge clk) begin
    if (load_a) for (int x = 0; x < 256; x++) sa_mem[x] <= m_s_init[x];
    else if (s_wren_a) sa_mem[s_addr_a] <= s_data_a;
    s_q_a   <= sa_mem[s_addr_a];
    rom_q_a <= m_rom[int'(rom_addr_a)];
  end

  always @(posedge clk) begin
    if (load_b) for (int x = 0; x < 256; x++) sb_mem[x] <= m_s_init[x];
    else if (s_wren_b) sb_mem[s_addr_b] <= s_data_b;
    s_q_b   <= sb_mem[s_addr_b];
    rom_q_b <= m_rom[int'(rom_addr_b)];
  end

  always @(posedge clk) begin
    if (clr_a) begin
      for (int x = 0; x < 16; x++) da_mem[x] <= 8'hEE;
      da_cnt <= 0; fa_cnt <= 0; both_a <= 1'b0;
    end else begin
      if (d_wren_a) begin da_mem[int'(d_addr_a)] <= d_data_a; da_cnt <= da_cnt + 1; end
      if (fin_a) fa_cnt <= fa_cnt + 1;
      if (s_wren_a && d_wren_a) both_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (clr_b) begin
      for (int x = 0; x < 16; x++) db_mem[x] <= 8'hEE;
      db_cnt <= 0; fb_cnt <= 0; both_b <= 1'b0;
    end else begin
      if (d_wren_b) begin db_mem[int'(d_addr_b)] <= d_data_b; db_cnt <= db_cnt + 1; end
      if (fin_b) fb_cnt <= fb_cnt + 1;
      if (s_wren_b && d_wren_b) both_b <= 1'b1;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_d[16];
  logic [7:0] exp_s[256];
  int exp_n;
  bit exp_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit printable(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
  endfunction

  // Plain RC4 PRGA over m_s_init/m_rom.
  task automatic model(input int len, input bit chk);
    int i, j, t;
    logic [7:0] ks, p;
    for (int x = 0; x < 256; x++) exp_s[x] = m_s_init[x];
    for (int x = 0; x < 16; x++) exp_d[x] = 8'hEE;
    i = 0; j = 0; exp_n = 0; exp_valid = 1'b1;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + exp_s[i]) % 256;
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t[7:0];
      ks = exp_s[(exp_s[i] + exp_s[j]) % 256];
      p = m_rom[k] ^ ks;
      exp_d[k] = p;
      exp_n++;
      if (chk && !printable(p)) begin exp_valid = 1'b0; break; end
    end
  endtask

  task automatic s_identity();
    for (int x = 0; x < 256; x++) m_s_init[x] = 8'(x);
  endtask

  task automatic s_shuffle();
    logic [7:0] t;
    int r;
    s_identity();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = m_s_init[x]; m_s_init[x] = m_s_init[r]; m_s_init[r] = t;
    end
  endtask

  task automatic ksa(input string key);
    int j;
    logic [7:0] t;
    s_identity();
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + m_s_init[x] + key[x % key.len()]) % 256;
      t = m_s_init[x]; m_s_init[x] = m_s_init[j]; m_s_init[j] = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic prep(input bit sel);
    @(negedge clk);
    if (sel) begin load_b = 1'b1; clr_b = 1'b1; end
    else     begin load_a = 1'b1; clr_a = 1'b1; end
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
  endtask

  // Returns cycles from the accepting edge to the edge raising finished (-1 on timeout).
  task automatic run(input bit sel, output int cyc);
    int n;
    bit done;
    n = 0; done = 1'b0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    while (!done && n < 400) begin
      @(posedge clk); n++;
      @(negedge clk);
      if ((sel ? fin_b : fin_a) === 1'b1) done = 1'b1;
    end
    cyc = done ? n - 1 : -1;
    start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_run(input string tag, input bit sel, input int cyc);
    int dm, sm;
    dm = 0; sm = 0;
    for (int x = 0; x < 16; x++) if ((sel ? db_mem[x] : da_mem[x]) !== exp_d[x]) dm++;
    for (int x = 0; x < 256; x++) if ((sel ? sb_mem[x] : sa_mem[x]) !== exp_s[x]) sm++;
    check({tag, ".cycles"}, cyc, exp_n * 10 + 1);
    check({tag, ".valid"}, sel ? valid_b : valid_a, exp_valid);
    check({tag, ".dwrites"}, sel ? db_cnt : da_cnt, exp_n);
    check({tag, ".finished_cnt"}, sel ? fb_cnt : fa_cnt, 1);
    check({tag, ".wren_overlap"}, sel ? both_b : both_a, 0);
    check({tag, ".d_mismatches"}, dm, 0);
    check({tag, ".s_mismatches"}, sm, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc, first_fin, pm;
    string pt;
    logic [7:0] ks[16];
    logic [7:0] ct9[9];
    logic [7:0] p8[16];

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int x = 0; x < 16; x++) m_rom[x] = 8'h00;
    s_identity();
    repeat (3) @(negedge clk);
    check("reset_a.ctrl", {fin_a, valid_a, s_wren_a, d_wren_a}, 4'h0);
    check("reset_a.addr", {s_addr_a, rom_addr_a, d_addr_a}, 10'h0);
    check("reset_a.data", {s_data_a, d_data_a}, 16'h0);
    check("reset_b.ctrl", {fin_b, valid_b, s_wren_b, d_wren_b}, 4'h0);
    check("reset_b.addr", {s_addr_b, rom_addr_b, d_addr_b}, 16'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // 1: identity S, two bytes decrypting to "aa"
    s_identity(); m_rom[0] = 8'h63; m_rom[1] = 8'h64;
    prep(0); run(0, cyc);
    check("s1.cycles", cyc, 21);
    check("s1.d0", da_mem[0], 8'h61);
    check("s1.d1", da_mem[1], 8'h61);
    check("s1.s1", sa_mem[1], 8'h01);
    check("s1.s2", sa_mem[2], 8'h03);
    check("s1.s3", sa_mem[3], 8'h02);
    check("s1.valid", valid_a, 1'b1);
    check("s1.finished_cnt", fa_cnt, 1);

    // 2: illegal first byte aborts after one write
    s_identity(); m_rom[0] = 8'h02; m_rom[1] = 8'h64;
    prep(0); run(0, cyc);
    check("s2.cycles", cyc, 11);
    check("s2.d0", da_mem[0], 8'h00);
    check("s2.d1_untouched", da_mem[1], 8'hEE);
    check("s2.dwrites", da_cnt, 1);
    check("s2.valid", valid_a, 1'b0);
    check("s2.finished_cnt", fa_cnt, 1);

    // 3: same bytes with checking disabled run to completion
    s_identity();
    for (int x = 2; x < 16; x++) m_rom[x] = 8'($urandom_range(255, 0));
    prep(1); run(1, cyc);
    model(16, 1'b0);
    check("s3.d0", db_mem[0], 8'h00);
    compare_run("s3", 1'b1, cyc);

    // 4a: published vector, key "Key", plaintext "Plaintext"
    ksa("Key");
    ct9 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int x = 0; x < 9; x++) m_rom[x] = ct9[x];
    for (int x = 9; x < 16; x++) m_rom[x] = 8'($urandom_range(255, 0));
    prep(1); run(1, cyc);
    pt = "Plaintext";
    pm = 0;
    for (int x = 0; x < 9; x++) if (db_mem[x] !== pt[x]) pm++;
    check("s4a.plaintext_mismatches", pm, 0);
    check("s4a.cycles", cyc, 161);

    // 4b: "attack at dawn" under key "Key", ciphertext built from model keystream
    ksa("Key");
    for (int x = 0; x < 16; x++) m_rom[x] = 8'h00;
    model(16, 1'b0);
    for (int x = 0; x < 16; x++) ks[x] = exp_d[x];
    pt = "attack at dawnxy";
    for (int x = 0; x < 16; x++) m_rom[x] = pt[x] ^ ks[x];
    model(16, 1'b0);
    prep(1); run(1, cyc);
    pm = 0;
    for (int x = 0; x < 16; x++) if (db_mem[x] !== pt[x]) pm++;
    check("s4b.plaintext_mismatches", pm, 0);
    compare_run("s4b", 1'b1, cyc);

    // 5: reset during byte 5 WRITE_J, then a clean rerun
    s_identity();
    for (int x = 0; x < 16; x++) m_rom[x] = 8'($urandom_range(255, 0));
    prep(1);
    @(negedge clk); start_b = 1'b1;
    repeat (56) @(posedge clk);
    @(negedge clk);
    check("s5.pre_reset_swap", {s_wren_b, s_addr_b}, {1'b1, 8'h06});
    rst_b = 1'b1; start_b = 1'b0;
    #1;
    check("s5.reset_ctrl", {fin_b, valid_b, s_wren_b, d_wren_b}, 4'h0);
    check("s5.reset_addr", {s_addr_b, rom_addr_b, d_addr_b}, 16'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (30) @(negedge clk);
    check("s5.aborted_dwrites", db_cnt, 5);
    check("s5.no_finished", fb_cnt, 0);
    model(16, 1'b0);
    prep(1); run(1, cyc);
    compare_run("s5_rerun", 1'b1, cyc);

    // 6: start held high with a re-toggle mid-run gives exactly one run
    s_identity(); m_rom[0] = 8'h63; m_rom[1] = 8'h64;
    prep(0);
    @(negedge clk); start_a = 1'b1;
    first_fin = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 8) start_a = 1'b0;
      if (c == 10) start_a = 1'b1;
      if (fin_a === 1'b1 && first_fin < 0) first_fin = c - 1;
    end
    start_a = 1'b0;
    check("s6.finished_cnt", fa_cnt, 1);
    check("s6.finished_cycle", first_fin, 21);
    check("s6.i_eq_j_s1", sa_mem[1], 8'h01);
    check("s6.dwrites", da_cnt, 2);

    // random: 16-byte decrypt with random S and ciphertext
    for (int it = 0; it < 3; it++) begin
      s_shuffle();
      for (int x = 0; x < 16; x++) m_rom[x] = 8'($urandom_range(255, 0));
      model(16, 1'b0);
      prep(1); run(1, cyc);
      compare_run($sformatf("rand_b%0d", it), 1'b1, cyc);
    end

    // random: 2-byte checked decrypt, some with an upper-case byte planted
    for (int it = 0; it < 4; it++) begin
      s_shuffle();
      for (int x = 0; x < 16; x++) m_rom[x] = 8'h00;
      model(2, 1'b0);
      for (int x = 0; x < 2; x++) ks[x] = exp_d[x];
      for (int x = 0; x < 2; x++) p8[x] = 8'($urandom_range(8'h7a, 8'h61));
      if (it == 1) p8[1] = 8'h41;
      if (it == 3) p8[0] = 8'h5a;
      for (int x = 0; x < 2; x++) m_rom[x] = p8[x] ^ ks[x];
      model(2, 1'b1);
      prep(0); run(0, cyc);
      compare_run($sformatf("rand_a%0d", it), 1'b0, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
